// File: rtl/inv_sbox_iterative.sv
// Sequential AES inverse S-box.
// Applies the inverse affine transform to the input byte, then raises the
// result to the power 254 in GF(2^8) mod 0x11B. A single shared multiplier
// does the work over 13 cycles. Valid/ready handshakes are used on both the
// input side and the output side.
module inv_sbox_iterative (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] byte_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] byte_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] x;
  logic [7:0] acc;
  logic [3:0] step;
  logic [7:0] mul_b;
  logic [7:0] prod;

  // Inverse affine: y[i] = b[i+2] ^ b[i+5] ^ b[i+7] (indices mod 8), then ^ 0x05
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] y;
    y[0] = b[2] ^ b[5] ^ b[7];
    y[1] = b[3] ^ b[6] ^ b[0];
    y[2] = b[4] ^ b[7] ^ b[1];
    y[3] = b[5] ^ b[0] ^ b[2];
    y[4] = b[6] ^ b[1] ^ b[3];
    y[5] = b[7] ^ b[2] ^ b[4];
    y[6] = b[0] ^ b[3] ^ b[5];
    y[7] = b[1] ^ b[4] ^ b[6];
    return y ^ 8'h05;
  endfunction

  // Shift-and-add GF(2^8) multiply, reducing by 0x11B on each shift
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      bb = bb >> 1;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Shared multiplier: even steps square acc, odd steps multiply acc by x
  always_comb begin
    mul_b = step[0] ? x : acc;
    prod  = gf_mul(acc, mul_b);
  end

  // Control FSM and datapath registers; reset takes priority over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      acc   <= '0;
      step  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= inv_affine(byte_in);
            acc   <= inv_affine(byte_in);
            step  <= '0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc  <= prod;
          step <= step + 4'd1;
          if (step == 4'd12) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only; no input reaches them directly
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == COMPUTE) || (state == DONE);
    byte_out  = (state == DONE) ? acc : '0;
  end

endmodule

// File: tb/tb_inv_sbox_iterative.sv
// Self-checking bench for inv_sbox_iterative.
// The reference InvSbox table is built by inverting a forward S-box. The
// forward S-box is computed as a brute-force GF inverse followed by the
// forward affine transform. A queue of expected bytes is filled when each
// input is accepted, and entries are removed as results come out.
module tb_inv_sbox_iterative;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] byte_in = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] byte_out;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int accept_cyc = 0;

  logic [7:0] invt [256];
  logic [7:0] exp_q [$];

  inv_sbox_iterative dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .byte_in   (byte_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .byte_out  (byte_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_inv(input logic [7:0] a);
    for (int y = 1; y < 256; y++)
      if (m_mul(a, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] a);
    logic [7:0] s;
    s = m_inv(a);
    return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  // Present b and wait a bounded time for in_ready, then take the accept edge.
  task automatic do_accept(input logic [7:0] b, output int ok);
    int n = 0;
    byte_in  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (in_ready === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    accept_cyc = cyc;
  endtask

  // Count edges from the accept until out_valid; -1 when the bound expires.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({in_ready, out_valid, busy, byte_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got rdy=%b vld=%b busy=%b out=%h required rdy=1 vld=0 busy=0 out=00",
                 k, in_ready, out_valid, busy, byte_out);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_known();
    logic [7:0] kin  [5] = '{8'h00, 8'h63, 8'h7C, 8'hED, 8'h16};
    logic [7:0] kexp [5] = '{8'h52, 8'h00, 8'h01, 8'h53, 8'hFF};
    logic [7:0] e;
    int ok, lat;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      do_accept(kin[k], ok);
      exp_q.push_back(kexp[k]);
      n_cmp++;
      if (ok != 1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL known_accept[%h]: got ok=%0d busy=%b rdy=%b required ok=1 busy=1 rdy=0",
                 kin[k], ok, busy, in_ready);
      end
      wait_valid(lat);
      n_cmp++;
      if (lat != 13) begin
        n_fail++;
        $display("FAIL known_latency[%h]: got %0d required 13", kin[k], lat);
      end
      e = pop_exp();
      n_cmp++;
      if (byte_out !== e) begin
        n_fail++;
        $display("FAIL known_value[%h]: got %h required %h", kin[k], byte_out, e);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL known_release[%h]: got vld=%b rdy=%b required vld=0 rdy=1",
                 kin[k], out_valid, in_ready);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] e;
    int ok, lat, prev;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      do_accept(8'(i), ok);
      exp_q.push_back(invt[i]);
      if (i > 0) begin
        n_cmp++;
        if (ok != 1 || accept_cyc - prev != 15) begin
          n_fail++;
          $display("FAIL sweep_spacing[%0d]: got ok=%0d spacing=%0d required ok=1 spacing=15",
                   i, ok, accept_cyc - prev);
        end
      end
      prev = accept_cyc;
      wait_valid(lat);
      e = pop_exp();
      n_cmp++;
      if (lat != 13 || byte_out !== e) begin
        n_fail++;
        $display("FAIL sweep_value[%02h]: got %h lat=%0d required %h lat=13", i, byte_out, lat, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    int ok, lat;
    out_ready = 1'b0;
    do_accept(8'h7C, ok);
    exp_q.push_back(8'h01);
    wait_valid(lat);
    n_cmp++;
    if (ok != 1 || lat != 13) begin
      n_fail++;
      $display("FAIL bp_latency: got ok=%0d lat=%0d required ok=1 lat=13", ok, lat);
    end
    in_valid = 1'b1;
    byte_in  = 8'hAA;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || byte_out !== exp_q[0] || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld=%b out=%h rdy=%b required vld=1 out=%h rdy=0",
                 k, out_valid, byte_out, in_ready, exp_q[0]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    e = pop_exp();
    n_cmp++;
    if (byte_out !== e) begin
      n_fail++;
      $display("FAIL bp_value: got %h required %h", byte_out, e);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    int ok, lat;
    logic seen;
    out_ready = 1'b1;
    do_accept(8'hED, ok);
    exp_q.push_back(8'h53);
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (ok != 1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_busy: got ok=%0d busy=%b vld=%b required ok=1 busy=1 vld=0", ok, busy, out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    n_cmp++;
    if ({in_ready, out_valid, busy, byte_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rmid_idle: got rdy=%b vld=%b busy=%b out=%h required rdy=1 vld=0 busy=0 out=00",
               in_ready, out_valid, busy, byte_out);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || byte_out !== 8'h00) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_quiet: got output activity=%b required 0", seen);
    end
    do_accept(8'h00, ok);
    exp_q.push_back(8'h52);
    wait_valid(lat);
    e = pop_exp();
    n_cmp++;
    if (ok != 1 || lat != 13 || byte_out !== e) begin
      n_fail++;
      $display("FAIL rmid_next: got ok=%0d lat=%0d out=%h required ok=1 lat=13 out=%h", ok, lat, byte_out, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_input_stability();
    logic [7:0] e;
    int ok, n;
    out_ready = 1'b1;
    do_accept(8'h16, ok);
    exp_q.push_back(8'hFF);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      byte_in  = 8'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    e = pop_exp();
    n_cmp++;
    if (ok != 1 || n != 13 || out_valid !== 1'b1 || byte_out !== e) begin
      n_fail++;
      $display("FAIL stability: got ok=%0d lat=%0d vld=%b out=%h required ok=1 lat=13 vld=1 out=%h",
               ok, n, out_valid, byte_out, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) invt[m_sbox(8'(a))] = 8'(a);
    test_reset();
    test_known();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_input_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
